// File: rtl/timer_counter_n_if.sv
// timer_counter_n_if: control/status bundle between the timer register file and timer_counter_n
//   master : register file side (drives controls, samples count and sticky flags)
//   slave  : counter side
interface timer_counter_n_if #(parameter int WIDTH = 8);
  logic [2:0]       clk_sel;
  logic [WIDTH-1:0] start_counter;
  logic             load;
  logic             up_down;
  logic             enable;
  logic             auto_reload;
  logic             clr_overflow;
  logic             clr_underflow;
  logic             clr_match;
  logic [WIDTH-1:0] compare;
  logic [WIDTH-1:0] count;
  logic             overflow;
  logic             underflow;
  logic             match;
  modport master (
    output clk_sel, start_counter, load, up_down, enable, auto_reload,
           clr_overflow, clr_underflow, clr_match, compare,
    input  count, overflow, underflow, match
  );
  modport slave (
    input  clk_sel, start_counter, load, up_down, enable, auto_reload,
           clr_overflow, clr_underflow, clr_match, compare,
    output count, overflow, underflow, match
  );
endinterface

// File: rtl/timer_counter_n.sv
// timer_counter_n: WIDTH-bit up/down timer with power-of-two prescaler, auto-reload and sticky flags
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : timer_counter_n_if.slave (clk_sel, start_counter, load, up_down, enable,
//                auto_reload, clr_*, compare in; count, overflow, underflow, match out)
//   TIMER_CMP_EN : when defined, enables the sticky compare-match flag; otherwise match is 0
module timer_counter_n #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  timer_counter_n_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] PONE = {{(PSC_W-1){1'b0}}, 1'b1};
  logic [WIDTH-1:0] cnt, cnt_nxt, rld;
  logic [PSC_W-1:0] psc, mask;
  logic             tick, step, at_max, at_min, ovf, unf, ovf_nxt, unf_nxt;
  // mask covers the low clk_sel prescaler bits; selections beyond PSC_W never tick
  always_comb begin
    mask    = ~({PSC_W{1'b1}} << bus.clk_sel);
    tick    = (bus.clk_sel == 3'd0) || ((32'(bus.clk_sel) <= PSC_W) && ((psc & mask) == mask));
    step    = bus.enable && tick && !bus.load;
    at_max  = cnt == MAX;
    at_min  = cnt == '0;
    cnt_nxt = bus.up_down ? (at_max ? (bus.auto_reload ? rld : '0) : cnt + ONE)
                          : (at_min ? (bus.auto_reload ? rld : MAX) : cnt - ONE);
    ovf_nxt = (step && bus.up_down && at_max) || (ovf && !bus.clr_overflow);
    unf_nxt = (step && !bus.up_down && at_min) || (unf && !bus.clr_underflow);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      rld <= '0;
      psc <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      psc <= bus.load ? '0 : psc + PONE;
      cnt <= bus.load ? bus.start_counter : (step ? cnt_nxt : cnt);
      rld <= bus.load ? bus.start_counter : rld;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
`ifdef TIMER_CMP_EN
  logic mat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mat <= 1'b0;
    else mat <= (step && cnt_nxt == bus.compare) ||
                (bus.load && bus.start_counter == bus.compare) ||
                (mat && !bus.clr_match);
  end
  assign bus.match = mat;
`else
  logic unused_cmp;
  assign unused_cmp = ^{bus.compare, bus.clr_match};
  assign bus.match  = 1'b0;
`endif
endmodule

// File: tb/tb_timer_counter_n.sv
// tb_timer_counter_n: directed self-checking bench for timer_counter_n (WIDTH=8, PSC_W=4)
module tb_timer_counter_n;
`ifdef TIMER_CMP_EN
  localparam logic CMP = 1'b1;
`else
  localparam logic CMP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  timer_counter_n_if #(.WIDTH(8)) bus ();
  timer_counter_n #(.WIDTH(8), .PSC_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_load(input logic [7:0] v);
    bus.start_counter = v;
    bus.load = 1'b1;
    edges(1);
    bus.load = 1'b0;
  endtask
  task automatic clear_flags();
    bus.enable = 1'b0;
    bus.clr_overflow = 1'b1;
    bus.clr_underflow = 1'b1;
    bus.clr_match = 1'b1;
    edges(1);
    bus.clr_overflow = 1'b0;
    bus.clr_underflow = 1'b0;
    bus.clr_match = 1'b0;
  endtask
  initial begin
    bus.clk_sel = 3'd0;
    bus.start_counter = 8'd0;
    bus.load = 1'b0;
    bus.up_down = 1'b1;
    bus.enable = 1'b0;
    bus.auto_reload = 1'b0;
    bus.clr_overflow = 1'b0;
    bus.clr_underflow = 1'b0;
    bus.clr_match = 1'b0;
    bus.compare = 8'd200;
    #3;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
    chk("rst_match", 32'(bus.match), 0);
    #9 rst_n = 1'b1;
    edges(1);
    // up wrap with clk_sel=1: tick on second edge after load
    bus.clk_sel = 3'd1;
    bus.up_down = 1'b1;
    bus.enable = 1'b1;
    do_load(8'd255);
    chk("up_load", 32'(bus.count), 255);
    edges(1);
    chk("up_pretick_count", 32'(bus.count), 255);
    chk("up_pretick_ovf", 32'(bus.overflow), 0);
    edges(1);
    chk("up_wrap_count", 32'(bus.count), 0);
    chk("up_wrap_ovf", 32'(bus.overflow), 1);
    chk("up_wrap_unf", 32'(bus.underflow), 0);
    // set/clear collision
    clear_flags();
    chk("ovf_cleared", 32'(bus.overflow), 0);
    bus.clk_sel = 3'd0;
    bus.enable = 1'b1;
    do_load(8'd255);
    bus.clr_overflow = 1'b1;
    edges(1);
    chk("collide_ovf", 32'(bus.overflow), 1);
    chk("collide_count", 32'(bus.count), 0);
    edges(1);
    chk("clear_ovf", 32'(bus.overflow), 0);
    chk("clear_count", 32'(bus.count), 1);
    bus.clr_overflow = 1'b0;
    // down wrap
    bus.up_down = 1'b0;
    do_load(8'd0);
    edges(1);
    chk("down_wrap_count", 32'(bus.count), 255);
    chk("down_wrap_unf", 32'(bus.underflow), 1);
    chk("down_wrap_ovf", 32'(bus.overflow), 0);
    // auto-reload up
    clear_flags();
    bus.enable = 1'b1;
    bus.up_down = 1'b1;
    bus.auto_reload = 1'b1;
    do_load(8'd253);
    edges(1);
    chk("ar_up_1", 32'(bus.count), 254);
    chk("ar_up_1_ovf", 32'(bus.overflow), 0);
    edges(1);
    chk("ar_up_2", 32'(bus.count), 255);
    edges(1);
    chk("ar_up_3", 32'(bus.count), 253);
    chk("ar_up_3_ovf", 32'(bus.overflow), 1);
    // auto-reload down
    bus.up_down = 1'b0;
    do_load(8'd2);
    edges(2);
    chk("ar_dn_2", 32'(bus.count), 0);
    chk("ar_dn_2_unf", 32'(bus.underflow), 0);
    edges(1);
    chk("ar_dn_3", 32'(bus.count), 2);
    chk("ar_dn_3_unf", 32'(bus.underflow), 1);
    // disabled: count holds
    bus.enable = 1'b0;
    edges(3);
    chk("hold_count", 32'(bus.count), 2);
    chk("hold_unf", 32'(bus.underflow), 1);
    // prescaler /16
    clear_flags();
    bus.auto_reload = 1'b0;
    bus.up_down = 1'b1;
    bus.enable = 1'b1;
    bus.clk_sel = 3'd4;
    do_load(8'd10);
    for (int i = 1; i <= 48; i++) begin
      edges(1);
      chk("psc16", 32'(bus.count), 32'(10 + i / 16));
    end
    // out-of-range select never ticks
    bus.clk_sel = 3'd7;
    edges(20);
    chk("sel7_hold", 32'(bus.count), 13);
    // asynchronous reset mid-count with a flag set
    bus.clk_sel = 3'd0;
    do_load(8'd255);
    edges(2);
    chk("pre_rst_ovf", 32'(bus.overflow), 1);
    chk("pre_rst_count", 32'(bus.count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.count), 0);
    chk("async_rst_ovf", 32'(bus.overflow), 0);
    chk("async_rst_unf", 32'(bus.underflow), 0);
    #1 rst_n = 1'b1;
    // compare match
    bus.enable = 1'b1;
    bus.compare = 8'd5;
    do_load(8'd3);
    chk("cmp_load", 32'(bus.match), 0);
    edges(1);
    chk("cmp_edge1_count", 32'(bus.count), 4);
    chk("cmp_edge1", 32'(bus.match), 0);
    edges(1);
    chk("cmp_edge2_count", 32'(bus.count), 5);
    chk("cmp_edge2", 32'(bus.match), 32'(CMP));
    edges(1);
    chk("cmp_sticky", 32'(bus.match), 32'(CMP));
    bus.clr_match = 1'b1;
    edges(1);
    chk("cmp_cleared", 32'(bus.match), 0);
    bus.clr_match = 1'b0;
    bus.enable = 1'b0;
    do_load(8'd5);
    chk("cmp_on_load", 32'(bus.match), 32'(CMP));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
